clause_region_allocator: RTL

- Next-generation bump allocator for the DDR learned-clause region, shared by all solver cores.
- Grants up to MAX_GRANTS allocations per cycle. Each granted core gets its own address, taken from a prefix-sum of aligned sizes in round-robin order.
- Enforces an upper region limit, rejects zero-size and oversize requests, and supports an epoch-based reclaim that rewinds the pointer after a garbage-collection pass.

---
 rtl/mega_alloc_pkg.sv | 20 ++
 rtl/rr_multi_picker.sv | 45 ++++
 rtl/clause_region_allocator.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mega_alloc_pkg.sv
// rtl/mega_alloc_pkg.sv - shared state type, word size and alignment helper for the region allocator
package mega_alloc_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXHAUSTED = 2'd1,
    RECLAIM   = 2'd2
  } alloc_state_e;

  localparam int WORD_BYTES = 4;

  // Round a word count up to the next multiple of a power-of-two granule.
  function automatic logic [31:0] align_up_words(input logic [31:0] size,
                                                 input logic [31:0] align_words);
    logic [31:0] mask;
    mask = align_words - 32'd1;
    return (size + mask) & ~mask;
  endfunction

endpackage

// File: rtl/rr_multi_picker.sv
// rtl/rr_multi_picker.sv - rotated-priority picker returning up to MAX_GRANTS one-hot selections
module rr_multi_picker #(
  parameter int NUM_CORES  = 4,
  parameter int MAX_GRANTS = 2,
  localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0]                  req,
  input  logic [IDX_W-1:0]                      rr_idx,
  output logic [MAX_GRANTS-1:0][NUM_CORES-1:0]  pick_onehot,
  output logic [MAX_GRANTS-1:0][IDX_W-1:0]      pick_idx,
  output logic [MAX_GRANTS-1:0]                 pick_valid,
  output logic [IDX_W-1:0]                      last_idx
);

  // Each slot takes the first still-available requester at or after rr_idx, so slot order is rotated order.
  always_comb begin
    logic [NUM_CORES-1:0] avail;
    logic [IDX_W-1:0]     idx;
    logic                 found;
    avail       = req;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = '0;
    last_idx    = rr_idx;
    idx         = '0;
    found       = 1'b0;
    for (int k = 0; k < MAX_GRANTS; k++) begin
      found = 1'b0;
      for (int o = 0; o < NUM_CORES; o++) begin
        idx = IDX_W'((int'(rr_idx) + o) % NUM_CORES);
        if (!found && avail[idx]) begin
          found         = 1'b1;
          pick_idx[k]   = idx;
          pick_valid[k] = 1'b1;
        end
      end
      if (found) begin
        pick_onehot[k] = NUM_CORES'(1) << pick_idx[k];
        avail          = avail & ~pick_onehot[k];
        last_idx       = pick_idx[k];
      end
    end
  end

endmodule

// File: rtl/clause_region_allocator.sv
// rtl/clause_region_allocator.sv - multi-grant bump allocator for the learned-clause region with epoch reclaim
module clause_region_allocator
  import mega_alloc_pkg::*;
#(
  parameter int                    NUM_CORES   = 4,
  parameter int                    MAX_GRANTS  = 2,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    SIZE_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] LIMIT_ADDR  = 32'h8000_0000,
  parameter int                    ALIGN_WORDS = 4,
  parameter int                    EPOCH_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            alloc_req,
  input  logic [NUM_CORES*SIZE_WIDTH-1:0] alloc_size,
  output logic [NUM_CORES-1:0]            alloc_grant,
  output logic [NUM_CORES-1:0]            alloc_fail,
  output logic [NUM_CORES*ADDR_WIDTH-1:0] alloc_addr,
  input  logic                            reclaim_req,
  output logic                            reclaim_done,
  output logic [EPOCH_WIDTH-1:0]          epoch,
  output logic                            exhausted,
  output logic [ADDR_WIDTH-1:0]           current_ptr,
  output logic [ADDR_WIDTH-1:0]           bytes_free
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW1   = ADDR_WIDTH + 1;

  alloc_state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]               rr_q, rr_d;
  logic [EPOCH_WIDTH-1:0]         epoch_q;
  logic                           done_q;
  logic [ADDR_WIDTH-1:0]          free_q;

  logic [NUM_CORES-1:0]           zero_req;
  logic [NUM_CORES-1:0]           live_req;
  logic [NUM_CORES-1:0][AW1-1:0]  req_bytes;

  logic [MAX_GRANTS-1:0][NUM_CORES-1:0] pick_onehot;
  logic [MAX_GRANTS-1:0][IDX_W-1:0]     pick_idx;
  logic [MAX_GRANTS-1:0]                pick_valid;
  logic [IDX_W-1:0]                     last_idx;

  logic [NUM_CORES-1:0]                 grant_d;
  logic [NUM_CORES-1:0]                 fail_d;
  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] addr_d;
  logic [AW1-1:0]                       run_sum;
  logic [AW1-1:0]                       end_sum;
  logic                                 blocked;

  // Split zero-size requests from real ones and convert each size to aligned bytes, one bit of overflow headroom.
  always_comb begin
    logic [SIZE_WIDTH-1:0] size_w;
    size_w    = '0;
    zero_req  = '0;
    live_req  = '0;
    req_bytes = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      size_w       = alloc_size[i*SIZE_WIDTH +: SIZE_WIDTH];
      zero_req[i]  = alloc_req[i] && (size_w == '0);
      live_req[i]  = alloc_req[i] && (size_w != '0);
      req_bytes[i] = AW1'(align_up_words(32'(size_w), 32'(ALIGN_WORDS))) * AW1'(WORD_BYTES);
    end
  end

  rr_multi_picker #(
    .NUM_CORES  (NUM_CORES),
    .MAX_GRANTS (MAX_GRANTS)
  ) u_picker (
    .req         (live_req),
    .rr_idx      (rr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid),
    .last_idx    (last_idx)
  );

  // Walk the picks as a prefix sum; the first one that overruns the limit blocks itself and all later picks.
  always_comb begin
    grant_d = '0;
    fail_d  = '0;
    addr_d  = '0;
    run_sum = {1'b0, ptr_q};
    end_sum = '0;
    blocked = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          fail_d = zero_req;
          for (int k = 0; k < MAX_GRANTS; k++) begin
            if (pick_valid[k]) begin
              end_sum = run_sum + req_bytes[pick_idx[k]];
              if (!blocked && (end_sum <= {1'b0, LIMIT_ADDR})) begin
                grant_d              = grant_d | pick_onehot[k];
                addr_d[pick_idx[k]]  = run_sum[ADDR_WIDTH-1:0];
                run_sum              = end_sum;
              end else begin
                blocked = 1'b1;
                fail_d  = fail_d | pick_onehot[k];
              end
            end
          end
        end
        EXHAUSTED: fail_d = alloc_req;
        default:   ;
      endcase
    end
  end

  // Next state, pointer and rotation; reclaim takes priority over exhaustion.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rr_d    = rr_q;
    case (state_q)
      RUN: begin
        ptr_d = run_sum[ADDR_WIDTH-1:0];
        if (|pick_valid) begin
          rr_d = IDX_W'((int'(last_idx) + 1) % NUM_CORES);
        end
        if (reclaim_req) begin
          state_d = RECLAIM;
        end else if (blocked) begin
          state_d = EXHAUSTED;
        end
      end
      EXHAUSTED: begin
        if (reclaim_req) begin
          state_d = RECLAIM;
        end
      end
      RECLAIM: begin
        state_d = RUN;
        ptr_d   = BASE_ADDR;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; leaving RECLAIM bumps the epoch and raises reclaim_done alongside the rewound pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ptr_q   <= BASE_ADDR;
      rr_q    <= '0;
      epoch_q <= '0;
      done_q  <= 1'b0;
      free_q  <= LIMIT_ADDR - BASE_ADDR;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rr_q    <= rr_d;
      done_q  <= (state_q == RECLAIM);
      free_q  <= LIMIT_ADDR - ptr_d;
      if (state_q == RECLAIM) begin
        epoch_q <= epoch_q + EPOCH_WIDTH'(1);
      end
    end
  end

  assign alloc_grant  = grant_d;
  assign alloc_fail   = fail_d;
  assign alloc_addr   = addr_d;
  assign reclaim_done = done_q;
  assign epoch        = epoch_q;
  assign exhausted    = (state_q == EXHAUSTED);
  assign current_ptr  = ptr_q;
  assign bytes_free   = free_q;

endmodule
